compound_accumulator: RTL and testbench

COMPOUND_ACCUMULATOR -- requirements
Module: compound_accumulator

---
 rtl/compound_accumulator.sv | 108 ++++++++++
 tb/tb_compound_accumulator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/compound_accumulator.sv
// rtl/compound_accumulator.sv - read/write accumulator with bias and a handshaked result port
package testbasic21_types;
  typedef enum logic {MODE_READ = 1'b0, MODE_WRITE = 1'b1} mode_t;

  typedef struct packed {
    mode_t              mode;
    logic signed [31:0] x;
    logic               y;
  } CompoundType;
endpackage

module compound_accumulator
  import testbasic21_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  CompoundType        b_in,
  input  logic               b_in_sync,
  output logic               b_in_notify,
  input  CompoundType        m_in,
  input  logic               m_in_sync,
  output logic signed [31:0] res_out,
  input  logic               res_out_sync,
  output logic               res_out_notify,
  output logic [15:0]        wr_count
);

  typedef enum logic {SECTION_GET, SECTION_SEND} section_t;

  section_t           r_section, w_section_n;
  logic signed [31:0] r_acc, w_acc_n;
  logic signed [31:0] r_bias, w_bias_n;
  logic signed [31:0] r_res, w_res_n;
  logic               r_res_notify, w_res_notify_n;
  logic               r_b_notify, w_b_notify_n;
  logic [15:0]        r_wr_count, w_wr_count_n;
  logic               w_accept;
  logic               w_unused_m;

  // Bias updates take only the payload; the remaining fields carry no meaning here.
  assign w_unused_m = ^{m_in.mode, m_in.y};

  assign w_accept = b_in_sync & r_b_notify;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_section    <= SECTION_GET;
      r_acc        <= '0;
      r_bias       <= '0;
      r_res        <= '0;
      r_res_notify <= 1'b0;
      r_b_notify   <= 1'b1;
      r_wr_count   <= '0;
    end else begin
      r_section    <= w_section_n;
      r_acc        <= w_acc_n;
      r_bias       <= w_bias_n;
      r_res        <= w_res_n;
      r_res_notify <= w_res_notify_n;
      r_b_notify   <= w_b_notify_n;
      r_wr_count   <= w_wr_count_n;
    end
  end

  always_comb begin
    w_section_n    = r_section;
    w_acc_n        = r_acc;
    w_bias_n       = r_bias;
    w_res_n        = r_res;
    w_res_notify_n = r_res_notify;
    w_b_notify_n   = r_b_notify;
    w_wr_count_n   = r_wr_count;

    case (r_section)
      SECTION_GET: begin
        if (w_accept) begin
          if (b_in.mode == MODE_WRITE) begin
            w_acc_n = b_in.y ? b_in.x : r_acc + b_in.x;
            if (r_wr_count != 16'hFFFF) w_wr_count_n = r_wr_count + 16'd1;
          end else begin
            // Result sees the pre-edge acc and bias; clear-on-read acts afterwards.
            w_res_n        = r_acc + r_bias;
            w_res_notify_n = 1'b1;
            w_b_notify_n   = 1'b0;
            w_section_n    = SECTION_SEND;
            if (b_in.y) w_acc_n = '0;
          end
        end
      end
      SECTION_SEND: begin
        if (res_out_sync) begin
          w_res_notify_n = 1'b0;
          w_b_notify_n   = 1'b1;
          w_section_n    = SECTION_GET;
        end
      end
      default: w_section_n = SECTION_GET;
    endcase

    if (m_in_sync) w_bias_n = m_in.x;
  end

  assign b_in_notify    = r_b_notify;
  assign res_out        = r_res;
  assign res_out_notify = r_res_notify;
  assign wr_count       = r_wr_count;

endmodule

// File: tb/tb_compound_accumulator.sv
// tb/tb_compound_accumulator.sv - randomized and directed checks against a behavioural model
module tb_compound_accumulator;
  import testbasic21_types::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  CompoundType        b_in;
  logic               b_in_sync = 1'b0;
  logic               b_in_notify;
  CompoundType        m_in;
  logic               m_in_sync = 1'b0;
  logic signed [31:0] res_out;
  logic               res_out_sync = 1'b0;
  logic               res_out_notify;
  logic [15:0]        wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: plain integers plus a "result pending" flag.
  logic [31:0] m_acc  = 0;
  logic [31:0] m_bias = 0;
  logic [31:0] m_res  = 0;
  int          m_wr   = 0;
  bit          m_busy = 0;

  compound_accumulator dut (
    .clk(clk), .rst(rst),
    .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(b_in_notify),
    .m_in(m_in), .m_in_sync(m_in_sync),
    .res_out(res_out), .res_out_sync(res_out_sync), .res_out_notify(res_out_notify),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    check_eq({tag, ".b_in_notify"}, {31'd0, b_in_notify}, {31'd0, !m_busy});
    check_eq({tag, ".res_out_notify"}, {31'd0, res_out_notify}, {31'd0, m_busy});
    check_eq({tag, ".res_out"}, res_out, m_res);
    check_eq({tag, ".wr_count"}, {16'd0, wr_count}, m_wr);
  endtask

  function automatic void model_reset();
    m_acc = 0; m_bias = 0; m_res = 0; m_wr = 0; m_busy = 0;
  endfunction

  // Called at a negedge; drives one cycle of inputs, advances the model, checks at the next negedge.
  task automatic step(input string tag, input bit bs, input bit wr, input logic [31:0] x,
                      input bit y, input bit ms, input logic [31:0] mx, input bit rs);
    b_in_sync    = bs;
    b_in.mode    = wr ? MODE_WRITE : MODE_READ;
    b_in.x       = x;
    b_in.y       = y;
    m_in_sync    = ms;
    m_in.mode    = MODE_WRITE;
    m_in.x       = mx;
    m_in.y       = ~y;
    res_out_sync = rs;
    if (!m_busy && bs) begin
      if (wr) begin
        m_acc = y ? x : m_acc + x;
        m_wr  = (m_wr >= 65535) ? 65535 : m_wr + 1;
      end else begin
        m_res  = m_acc + m_bias;
        m_busy = 1;
        if (y) m_acc = 0;
      end
    end else if (m_busy && rs) begin
      m_busy = 0;
    end
    if (ms) m_bias = mx;
    @(posedge clk);
    @(negedge clk);
    compare_model(tag);
  endtask

  task automatic idle(input string tag, input bit rs);
    step(tag, 0, 0, 0, 0, 0, 0, rs);
  endtask

  task automatic wr_op(input string tag, input logic [31:0] x, input bit y);
    step(tag, 1, 1, x, y, 0, 0, 0);
  endtask

  task automatic rd_op(input string tag, input bit y);
    step(tag, 1, 0, 0, y, 0, 0, 0);
  endtask

  // Async reset asserted at a negedge; outputs must change before any clock edge.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq({tag, ".rst_res_out"}, res_out, 32'd0);
    check_eq({tag, ".rst_res_notify"}, {31'd0, res_out_notify}, 32'd0);
    check_eq({tag, ".rst_b_notify"}, {31'd0, b_in_notify}, 32'd1);
    check_eq({tag, ".rst_wr_count"}, {16'd0, wr_count}, 32'd0);
    model_reset();
    b_in_sync = 0; m_in_sync = 0; res_out_sync = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    b_in = '0;
    m_in = '0;
    @(negedge clk);
    apply_reset("init");

    // Accumulating writes then a read with a one-cycle-late acknowledge
    wr_op("s1w0", 32'd5, 0);
    wr_op("s1w1", -32'sd2, 0);
    rd_op("s1rd", 0);
    check_eq("s1.res", res_out, 32'd3);
    check_eq("s1.notify_on", {31'd0, res_out_notify}, 32'd1);
    idle("s1ack", 1);
    check_eq("s1.notify_off", {31'd0, res_out_notify}, 32'd0);
    check_eq("s1.wr_count", {16'd0, wr_count}, 32'd2);

    // Load, bias update, read-and-clear, then read again
    wr_op("s2w", 32'd7, 1);
    step("s2m", 0, 0, 0, 0, 1, 32'd10, 0);
    step("s2rd", 1, 0, 0, 1, 0, 0, 1);
    check_eq("s2.res", res_out, 32'd17);
    idle("s2ack", 1);
    rd_op("s2rd2", 0);
    check_eq("s2.res2", res_out, 32'd10);
    idle("s2ack2", 1);

    // Signed overflow wraps silently
    step("s3m", 0, 0, 0, 0, 1, 32'd0, 0);
    wr_op("s3w0", 32'h7FFFFFFF, 1);
    wr_op("s3w1", 32'd1, 0);
    rd_op("s3rd", 0);
    check_eq("s3.res", res_out, 32'h80000000);
    idle("s3ack", 1);

    // Back-pressure: result held, requests ignored
    rd_op("s4rd", 0);
    for (int i = 0; i < 5; i++) begin
      step("s4hold", i[0], 1, 32'd99, 0, 0, 0, 0);
      check_eq("s4.res_stable", res_out, 32'h80000000);
      check_eq("s4.b_notify", {31'd0, b_in_notify}, 32'd0);
    end
    check_eq("s4.wr_count", {16'd0, wr_count}, 32'd5);
    idle("s4ack", 1);

    // Bias update coincident with a read uses the old bias
    wr_op("s5w", 32'd4, 1);
    step("s5m", 0, 0, 0, 0, 1, 32'd1, 0);
    step("s5rd", 1, 0, 0, 0, 1, 32'd100, 0);
    check_eq("s5.res", res_out, 32'd5);
    idle("s5ack", 1);
    rd_op("s5rd2", 0);
    check_eq("s5.res2", res_out, 32'd104);

    // Reset while a result is pending
    apply_reset("s6");
    wr_op("s6w", 32'd9, 0);
    rd_op("s6rd", 0);
    check_eq("s6.res", res_out, 32'd9);
    idle("s6ack", 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom,
           $urandom_range(0, 1) == 1);
    end
    idle("rnd_drain", 1);

    // Write counter saturation
    apply_reset("sat");
    for (int i = 0; i < 65540; i++) begin
      step("sat", 1, 1, 32'd1, 0, 0, 0, 0);
    end
    check_eq("sat.wr_count", {16'd0, wr_count}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
